// File: rtl/fm_pkg.sv
// Shared types and constants for the fast-multiplier chip.
package fm_pkg;

   localparam int DATA_W      = 8;
   localparam int N           = 4;
   localparam int ACC_W       = 16;
   localparam int LOAD_CYCLES = 5;
   localparam int MM_CYCLES   = 12;
   localparam int NREG        = 2 * N;
   localparam int CNT_W       = 4;

   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] MM_LAST   = CNT_W'(MM_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_MATMUL = 2'd2,
      ST_DONE   = 2'd3
   } fm_state_e;

   // Field view of the 7-bit AUX command bus.
   typedef struct packed {
      logic [2:0] reg_sel;
      logic [1:0] idx;
      logic       load;
      logic       write;
   } aux_t;

   typedef logic [N-1:0][N-1:0][DATA_W-1:0] opmat_t;
   typedef logic [N-1:0][N-1:0][ACC_W-1:0]  accmat_t;

   // Pick the upper or lower byte of a 16-bit result word.
   function automatic logic [DATA_W-1:0] sel_byte(input logic [ACC_W-1:0] w, input logic hi);
      return hi ? w[ACC_W-1:DATA_W] : w[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/fm_if.sv
// Host-side pad bundle of the fast-multiplier chip.
interface fm_if;
   import fm_pkg::*;

   logic              en;
   logic [6:0]        AUX;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] DATA_OUT;
   logic              INTERRUPT_PIN;
   logic              READ_LED;
   logic              WRITE_LED;
   logic              LOAD_LED;
   logic              MATMUL_LED;
   logic              EN_LED;

   modport master (
      output en, AUX, data_in,
      input  DATA_OUT, INTERRUPT_PIN, READ_LED, WRITE_LED, LOAD_LED, MATMUL_LED, EN_LED
   );

   modport slave (
      input  en, AUX, data_in,
      output DATA_OUT, INTERRUPT_PIN, READ_LED, WRITE_LED, LOAD_LED, MATMUL_LED, EN_LED
   );

endinterface

// File: rtl/matmul_core.sv
// 4x4 multiply-accumulate array: one rank-1 update (column k of A times row k
// of B) per cycle, so a full product takes N cycles after start.
module matmul_core
   import fm_pkg::*;
(
   input  logic    clk_i,
   input  logic    clear_i,
   input  logic    start_i,
   input  opmat_t  a_i,
   input  opmat_t  b_i,
   output accmat_t c_o,
   output logic    done_o
);

   logic [1:0] k_q;
   logic       busy_q;
   logic       done_q;
   accmat_t    acc_q;
   accmat_t    acc_d;

   // Next accumulator value: add the k-th outer product to every cell.
   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            acc_d[i][j] = acc_q[i][j] + (ACC_W'(a_i[i][k_q]) * ACC_W'(b_i[k_q][j]));
         end
      end
   end

   // Sequencer: clear accumulators on start, step k while busy, flag done.
   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         acc_q  <= '0;
         k_q    <= 2'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start_i) begin
         acc_q  <= '0;
         k_q    <= 2'd0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         acc_q <= acc_d;
         k_q   <= k_q + 2'd1;
         if (k_q == 2'(N - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   assign c_o    = acc_q;
   assign done_o = done_q;

endmodule

// File: rtl/chip_top.sv
// Pad-level top of the fast-multiplier chip: command decode, FSM, operand and
// result files, read mux, status LEDs.
module chip_top
   import fm_pkg::*;
(
   input logic  clk,
   input logic  clear,
   fm_if.slave  bus
);

   fm_state_e                          state_q;
   logic [CNT_W-1:0]                   cnt_q;
   logic [NREG-1:0][N-1:0][DATA_W-1:0] op_q;
   accmat_t                            res_q;
   opmat_t                             snap_a_q;
   opmat_t                             snap_b_q;
   logic                               start_q;
   logic [DATA_W-1:0]                  data_out_q;
   logic                               irq_q;

   aux_t              aux_s;
   logic              busy_s;
   logic [DATA_W-1:0] rd_byte_s;
   accmat_t           core_c_s;
   logic              core_done_s;

   assign aux_s     = aux_t'(bus.AUX);
   assign busy_s    = (state_q == ST_LOAD) || (state_q == ST_MATMUL);
   assign rd_byte_s = sel_byte(res_q[aux_s.reg_sel[1:0]][aux_s.idx], aux_s.reg_sel[2]);

   matmul_core u_core (
      .clk_i   (clk),
      .clear_i (clear),
      .start_i (start_q),
      .a_i     (snap_a_q),
      .b_i     (snap_b_q),
      .c_o     (core_c_s),
      .done_o  (core_done_s)
   );

   // Main FSM with operand/result files and registered host outputs.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         res_q      <= '0;
         snap_a_q   <= '0;
         snap_b_q   <= '0;
         start_q    <= 1'b0;
         data_out_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.en) begin
                  if (aux_s.load) begin
                     state_q <= ST_LOAD;
                     cnt_q   <= '0;
                     irq_q   <= 1'b0;
                  end else if (aux_s.write) begin
                     op_q[aux_s.reg_sel][aux_s.idx] <= bus.data_in;
                     irq_q <= 1'b0;
                  end else begin
                     data_out_q <= rd_byte_s;
                  end
               end
            end
            ST_LOAD: begin
               if (cnt_q == LOAD_LAST) begin
                  // Operand writes are blocked while busy, so the file is stable here.
                  snap_a_q <= op_q[N-1:0];
                  snap_b_q <= op_q[NREG-1:N];
                  start_q  <= 1'b1;
                  state_q  <= ST_MATMUL;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_MATMUL: begin
               if (cnt_q == MM_LAST) begin
                  // The core finishes in N+1 cycles, well inside the MATMUL window.
                  if (core_done_s) begin
                     res_q <= core_c_s;
                  end
                  state_q <= ST_DONE;
                  cnt_q   <= '0;
                  irq_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.DATA_OUT      = data_out_q;
   assign bus.INTERRUPT_PIN = irq_q;
   assign bus.EN_LED        = bus.en;
   assign bus.WRITE_LED     = ~clear & bus.en & ~aux_s.load & aux_s.write & ~busy_s;
   assign bus.READ_LED      = ~clear & bus.en & ~aux_s.load & ~aux_s.write & ~busy_s;
   assign bus.LOAD_LED      = (state_q == ST_LOAD);
   assign bus.MATMUL_LED    = (state_q == ST_MATMUL);

endmodule

// File: tb/tb_chip_top.sv
// Self-checking bench for chip_top: read-back tables, a shadow operand model
// with a read scoreboard, and hand-written busy/clear/interrupt sequences.
module tb_chip_top;
   import fm_pkg::*;

   logic clk;
   logic clear;
   fm_if bus ();

   chip_top dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         row;
      int         col;
      bit         hi;
      logic [7:0] exp;
   } rd_vec_t;

   int         n_vec  = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_rd;
   logic [7:0] m_op [8][4];
   logic [15:0] m_c [4][4];
   rd_vec_t    tbl [32];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.en      = 1'b0;
      bus.AUX     = 7'd0;
      bus.data_in = 8'd0;
   endtask

   task automatic wr(input int r, input int i, input logic [7:0] d);
      bus.en      = 1'b1;
      bus.AUX     = {3'(r), 2'(i), 1'b0, 1'b1};
      bus.data_in = d;
      m_op[r][i]  = d;
      step();
      idle();
   endtask

   task automatic rd(input string name, input int row, input int col, input bit hi, input logic [7:0] exp);
      logic [7:0] want;
      bus.en  = 1'b1;
      bus.AUX = {hi, 2'(row), 2'(col), 2'b00};
      exp_q.push_back(exp);
      step();
      want    = exp_q.pop_front();
      last_rd = want;
      check(name, 32'(bus.DATA_OUT), 32'(want));
      idle();
   endtask

   function automatic void model();
      int s;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += int'(m_op[i][k]) * int'(m_op[4+k][j]);
            m_c[i][j] = 16'(s);
         end
      end
   endfunction

   function automatic logic [7:0] mbyte(input int row, input int col, input bit hi);
      logic [15:0] w;
      w = m_c[row][col];
      return hi ? w[15:8] : w[7:0];
   endfunction

   // Issue a load, wait (bounded) for the interrupt and check its latency.
   task automatic run_load(input string name, input bit trace);
      int c;
      logic [2:0] want;
      bus.en  = 1'b1;
      bus.AUX = 7'b000_00_1_0;
      step();
      idle();
      c = 0;
      if (trace) check({name, "_c0"}, {29'd0, bus.LOAD_LED, bus.MATMUL_LED, bus.INTERRUPT_PIN}, 32'b100);
      while (c < 40 && bus.INTERRUPT_PIN !== 1'b1) begin
         step();
         c++;
         if (trace) begin
            want = {1'(c < 5), 1'(c >= 5 && c < 17), 1'(c >= 17)};
            check($sformatf("%s_c%0d", name, c),
                  {29'd0, bus.LOAD_LED, bus.MATMUL_LED, bus.INTERRUPT_PIN}, {29'd0, want});
         end
      end
      check({name, "_latency"}, 32'(c), 32'd17);
      model();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int clo [16];
      int c;
      clo = '{18, 15, 21, 7, 10, 20, 11, 12, 30, 30, 28, 20, 24, 20, 26, 12};
      for (int r = 0; r < 8; r++) for (int i = 0; i < 4; i++) m_op[r][i] = 8'd0;
      last_rd = 8'd0;

      // 1. reset
      idle();
      clear = 1'b1;
      step();
      check("rst_en_led_off", 32'(bus.EN_LED), 32'd0);
      bus.en = 1'b1;
      step();
      check("rst_data_out", 32'(bus.DATA_OUT), 32'd0);
      check("rst_irq", 32'(bus.INTERRUPT_PIN), 32'd0);
      check("rst_leds", {28'd0, bus.READ_LED, bus.WRITE_LED, bus.LOAD_LED, bus.MATMUL_LED}, 32'd0);
      check("rst_en_led_on", 32'(bus.EN_LED), 32'd1);
      clear = 1'b0;
      idle();
      step();

      // 2. reference matrices
      bus.en  = 1'b1;
      bus.AUX = 7'b000_00_0_1;
      #1;
      check("write_led_idle", {30'd0, bus.WRITE_LED, bus.READ_LED}, 32'b10);
      idle();
      begin
         int av [16];
         int bv [16];
         av = '{0, 2, 3, 1, 0, 2, 0, 3, 1, 2, 4, 4, 0, 2, 4, 2};
         bv = '{2, 2, 0, 0, 2, 4, 4, 0, 4, 1, 4, 1, 2, 4, 1, 4};
         for (int n = 0; n < 16; n++) wr(n / 4, n % 4, 8'(av[n]));
         for (int n = 0; n < 16; n++) wr(4 + n / 4, n % 4, 8'(bv[n]));
      end
      run_load("t2", 1'b1);
      for (int n = 0; n < 16; n++) begin
         tbl[n]      = '{row: n / 4, col: n % 4, hi: 1'b0, exp: 8'(clo[n])};
         tbl[16 + n] = '{row: n / 4, col: n % 4, hi: 1'b1, exp: 8'd0};
      end
      for (int v = 0; v < 32; v++)
         rd($sformatf("t2_C%0d%0d_%s", tbl[v].row, tbl[v].col, tbl[v].hi ? "hi" : "lo"),
            tbl[v].row, tbl[v].col, tbl[v].hi, tbl[v].exp);

      // 3. identity A, one B byte changed
      for (int n = 0; n < 16; n++) wr(n / 4, n % 4, (n / 4 == n % 4) ? 8'd1 : 8'd0);
      bus.en      = 1'b1;
      bus.AUX     = 7'b111_11_0_1;
      bus.data_in = 8'd8;
      m_op[7][3]  = 8'd8;
      step();
      idle();
      run_load("t3", 1'b0);
      rd("t3_C33", 3, 3, 1'b0, 8'd8);
      for (int j = 0; j < 3; j++) rd($sformatf("t3_C3%0d", j), 3, j, 1'b0, mbyte(3, j, 1'b0));

      // 4. saturating operands: 4*255*255 truncated to 16 bits
      for (int n = 0; n < 32; n++) wr(n / 4, n % 4, 8'hFF);
      run_load("t4", 1'b0);
      rd("t4_C00_lo", 0, 0, 1'b0, 8'h04);
      rd("t4_C00_hi", 0, 0, 1'b1, 8'hF8);
      rd("t4_C32_lo", 3, 2, 1'b0, 8'h04);
      rd("t4_C32_hi", 3, 2, 1'b1, 8'hF8);

      // 5a. write and read attempts while busy
      for (int n = 0; n < 32; n++) wr(n / 4, n % 4, 8'((n * 7 + 3) & 8'hFF));
      bus.en  = 1'b1;
      bus.AUX = 7'b000_00_1_0;
      step();
      idle();
      c = 0;
      while (c < 10 && bus.MATMUL_LED !== 1'b1) begin
         step();
         c++;
      end
      check("t5_reach_matmul", 32'(c), 32'd5);
      bus.en      = 1'b1;
      bus.AUX     = 7'b000_00_0_1;
      bus.data_in = 8'hAA;
      #1;
      check("t5_write_led_busy", 32'(bus.WRITE_LED), 32'd0);
      step();
      bus.AUX = 7'b100_00_0_0;
      step();
      check("t5_dout_hold", 32'(bus.DATA_OUT), 32'(last_rd));
      idle();
      c = 0;
      while (c < 20 && bus.INTERRUPT_PIN !== 1'b1) begin
         step();
         c++;
      end
      check("t5_irq_seen", 32'(bus.INTERRUPT_PIN), 32'd1);
      model();
      rd("t5_C00_lo", 0, 0, 1'b0, mbyte(0, 0, 1'b0));
      rd("t5_C00_hi", 0, 0, 1'b1, mbyte(0, 0, 1'b1));
      run_load("t5_reload", 1'b0);
      rd("t5_re_C01_lo", 0, 1, 1'b0, mbyte(0, 1, 1'b0));
      rd("t5_re_C00_lo", 0, 0, 1'b0, mbyte(0, 0, 1'b0));

      // 5b. clear during LOAD aborts the run
      bus.en  = 1'b1;
      bus.AUX = 7'b000_00_1_0;
      step();
      idle();
      step();
      check("t5_in_load", 32'(bus.LOAD_LED), 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t5_clr_state", {30'd0, bus.LOAD_LED, bus.MATMUL_LED}, 32'd0);
      check("t5_clr_dout", 32'(bus.DATA_OUT), 32'd0);
      c = 0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (bus.INTERRUPT_PIN !== 1'b0 || bus.MATMUL_LED !== 1'b0) c++;
      end
      check("t5_clr_no_irq", 32'(c), 32'd0);
      for (int r = 0; r < 8; r++) for (int i = 0; i < 4; i++) m_op[r][i] = 8'd0;
      model();
      rd("t5_clr_C21", 2, 1, 1'b0, 8'd0);

      // 6. interrupt persistence
      for (int n = 0; n < 32; n++) wr(n / 4, n % 4, 8'((n + 1) * 5));
      run_load("t6", 1'b0);
      rd("t6_C11_lo", 1, 1, 1'b0, mbyte(1, 1, 1'b0));
      check("t6_irq_after_read", 32'(bus.INTERRUPT_PIN), 32'd1);
      bus.en      = 1'b0;
      bus.AUX     = 7'b000_00_0_1;
      bus.data_in = 8'h55;
      step();
      idle();
      check("t6_irq_en0_write", 32'(bus.INTERRUPT_PIN), 32'd1);
      wr(1, 0, m_op[1][0]);
      check("t6_irq_drop", 32'(bus.INTERRUPT_PIN), 32'd0);
      run_load("t6_reload", 1'b0);
      for (int j = 0; j < 4; j++) rd($sformatf("t6_C0%0d_lo", j), 0, j, 1'b0, mbyte(0, j, 1'b0));
      rd("t6_C03_hi", 0, 3, 1'b1, mbyte(0, 3, 1'b1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
